// File: rtl/resize_gain_ctrl.sv
`default_nettype none
//============================================================================
// Module   : resize_gain_ctrl
// Brief    : Automatic gain controller for the runtime-shift resizer. Each
//            measurement window tracks the peak lane magnitude and the
//            resizer warning count, then steps the shift by +1, -1 or holds
//            it. Measurement is blanked while the resizer pipeline flushes.
//            Optional window statistics outputs: RESIZE_GAIN_CTRL_STATS_EN.
// Revision : 1.0 - initial release
//============================================================================
module resize_gain_ctrl #(
    parameter int DOUT_WIDTH    = 9,
    parameter int PARALLEL      = 4,
    parameter int SHIFT_W       = 5,
    parameter int SHIFT_MIN     = -8,
    parameter int SHIFT_MAX     = 8,
    parameter int SHIFT_INIT    = 0,
    parameter int WINDOW        = 1024,
    parameter int SETTLE_CYCLES = 4,
    parameter int HEADROOM_BITS = 1,
    parameter int OVF_LIMIT     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic [DOUT_WIDTH*PARALLEL-1:0] dout_mon,
    input  logic                           dout_mon_valid,
    input  logic                           warning_in,
    output logic signed [SHIFT_W-1:0]      shift_out,
    output logic                           shift_update,
    output logic                           locked,
    output logic                           at_rail
`ifdef RESIZE_GAIN_CTRL_STATS_EN
    ,
    output logic [DOUT_WIDTH:0]            stat_peak,
    output logic [15:0]                    stat_warn
`endif
);

    localparam int BEAT_W   = $clog2(WINDOW + 1);
    localparam int WARN_W   = $clog2(OVF_LIMIT + 1);
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [BEAT_W-1:0]       c_BEAT_LAST   = BEAT_W'(WINDOW - 1);
    localparam logic [WARN_W-1:0]       c_WARN_LIMIT  = WARN_W'(OVF_LIMIT);
    localparam logic [SETTLE_W-1:0]     c_SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    // Peak below this leaves at least HEADROOM_BITS spare above one extra bit
    localparam logic [DOUT_WIDTH-1:0]   c_LOW_THRESH  = DOUT_WIDTH'(1 << (DOUT_WIDTH - 2 - HEADROOM_BITS));
    localparam logic signed [SHIFT_W:0] c_SHIFT_MIN_X = (SHIFT_W + 1)'(SHIFT_MIN);
    localparam logic signed [SHIFT_W:0] c_SHIFT_MAX_X = (SHIFT_W + 1)'(SHIFT_MAX);
    localparam logic signed [SHIFT_W-1:0] c_SHIFT_INIT = SHIFT_W'(SHIFT_INIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_DECIDE  = 2'd2,
        S_SETTLE  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [BEAT_W-1:0]          r_beat_cnt,   w_beat_nxt;
    logic [DOUT_WIDTH-1:0]      r_peak,       w_peak_nxt;
    logic [WARN_W-1:0]          r_warn_cnt,   w_warn_nxt;
    logic [SETTLE_W-1:0]        r_settle_cnt, w_settle_nxt;
    logic signed [SHIFT_W-1:0]  r_shift,      w_shift_nxt;
    logic                       r_shift_update, w_upd_nxt;
    logic                       r_locked,     w_locked_nxt;
    logic                       r_at_rail,    w_rail_nxt;

    logic [DOUT_WIDTH-1:0]      w_lane;
    logic [DOUT_WIDTH-1:0]      w_lane_abs;
    logic [DOUT_WIDTH-1:0]      w_beat_peak;
    logic signed [SHIFT_W:0]    w_shift_ext;
    logic signed [SHIFT_W:0]    w_shift_dn;
    logic signed [SHIFT_W:0]    w_shift_up;
    logic                       w_want_dec;
    logic                       w_want_inc;

    // Largest lane magnitude in the current beat; the unsigned view of the
    // negated most-negative code is exactly 2^(DOUT_WIDTH-1), so no wrap.
    always_comb begin
        w_lane      = '0;
        w_lane_abs  = '0;
        w_beat_peak = '0;
        for (int i = 0; i < PARALLEL; i++) begin
            w_lane     = dout_mon[i*DOUT_WIDTH +: DOUT_WIDTH];
            w_lane_abs = w_lane[DOUT_WIDTH-1] ? (~w_lane + DOUT_WIDTH'(1)) : w_lane;
            if (w_lane_abs > w_beat_peak) begin
                w_beat_peak = w_lane_abs;
            end
        end
    end

    // Candidate shifts one step either way, one bit wider so rails compare cleanly
    assign w_shift_ext = {r_shift[SHIFT_W-1], r_shift};
    assign w_shift_dn  = w_shift_ext - (SHIFT_W + 1)'(1);
    assign w_shift_up  = w_shift_ext + (SHIFT_W + 1)'(1);
    // Overflow evidence outranks a low peak in the same window
    assign w_want_dec  = (r_warn_cnt >= c_WARN_LIMIT);
    assign w_want_inc  = !w_want_dec && (r_peak < c_LOW_THRESH);

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt  = r_state;
        w_beat_nxt   = r_beat_cnt;
        w_peak_nxt   = r_peak;
        w_warn_nxt   = r_warn_cnt;
        w_settle_nxt = r_settle_cnt;
        w_shift_nxt  = r_shift;
        w_upd_nxt    = 1'b0;
        w_locked_nxt = r_locked;
        w_rail_nxt   = r_at_rail;

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (warning_in && (r_warn_cnt < c_WARN_LIMIT)) begin
                    w_warn_nxt = r_warn_cnt + WARN_W'(1);
                end
                if (dout_mon_valid) begin
                    w_beat_nxt = r_beat_cnt + BEAT_W'(1);
                    if (w_beat_peak > r_peak) begin
                        w_peak_nxt = w_beat_peak;
                    end
                    if (r_beat_cnt == c_BEAT_LAST) begin
                        w_state_nxt = S_DECIDE;
                    end
                end
            end
            S_DECIDE: begin
                w_beat_nxt = '0;
                w_peak_nxt = '0;
                w_warn_nxt = '0;
                if (w_want_dec || w_want_inc) begin
                    w_locked_nxt = 1'b0;
                    if (w_want_dec && (w_shift_dn >= c_SHIFT_MIN_X)) begin
                        w_shift_nxt = w_shift_dn[SHIFT_W-1:0];
                        w_upd_nxt   = 1'b1;
                        w_rail_nxt  = 1'b0;
                        w_state_nxt = S_SETTLE;
                    end else if (w_want_inc && (w_shift_up <= c_SHIFT_MAX_X)) begin
                        w_shift_nxt = w_shift_up[SHIFT_W-1:0];
                        w_upd_nxt   = 1'b1;
                        w_rail_nxt  = 1'b0;
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_rail_nxt  = 1'b1;
                        w_state_nxt = S_MEASURE;
                    end
                end else begin
                    w_locked_nxt = 1'b1;
                    w_rail_nxt   = 1'b0;
                    w_state_nxt  = S_MEASURE;
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == c_SETTLE_LAST) begin
                    w_settle_nxt = '0;
                    w_state_nxt  = S_MEASURE;
                end else begin
                    w_settle_nxt = r_settle_cnt + SETTLE_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Run control overrides everything; a pending decision is dropped
        if (!enable) begin
            w_state_nxt  = S_IDLE;
            w_beat_nxt   = '0;
            w_peak_nxt   = '0;
            w_warn_nxt   = '0;
            w_settle_nxt = '0;
            w_shift_nxt  = r_shift;
            w_upd_nxt    = 1'b0;
            w_locked_nxt = r_locked;
            w_rail_nxt   = r_at_rail;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulators and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt     <= '0;
            r_peak         <= '0;
            r_warn_cnt     <= '0;
            r_settle_cnt   <= '0;
            r_shift        <= c_SHIFT_INIT;
            r_shift_update <= 1'b0;
            r_locked       <= 1'b0;
            r_at_rail      <= 1'b0;
        end else begin
            r_beat_cnt     <= w_beat_nxt;
            r_peak         <= w_peak_nxt;
            r_warn_cnt     <= w_warn_nxt;
            r_settle_cnt   <= w_settle_nxt;
            r_shift        <= w_shift_nxt;
            r_shift_update <= w_upd_nxt;
            r_locked       <= w_locked_nxt;
            r_at_rail      <= w_rail_nxt;
        end
    end

    assign shift_out    = r_shift;
    assign shift_update = r_shift_update;
    assign locked       = r_locked;
    assign at_rail      = r_at_rail;

`ifdef RESIZE_GAIN_CTRL_STATS_EN
    logic [15:0]           r_warn_full;
    logic [15:0]           w_warn_full_nxt;
    logic [DOUT_WIDTH:0]   r_stat_peak;
    logic [15:0]           r_stat_warn;

    // Full-range warning count for the window, saturating at 16 bits
    always_comb begin
        w_warn_full_nxt = r_warn_full;
        if (!enable || (r_state == S_DECIDE)) begin
            w_warn_full_nxt = '0;
        end else if ((r_state == S_MEASURE) && warning_in && (r_warn_full != 16'hFFFF)) begin
            w_warn_full_nxt = r_warn_full + 16'd1;
        end
    end

    // Snapshot window statistics when a decision is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warn_full <= '0;
            r_stat_peak <= '0;
            r_stat_warn <= '0;
        end else begin
            r_warn_full <= w_warn_full_nxt;
            if ((r_state == S_DECIDE) && enable) begin
                r_stat_peak <= {1'b0, r_peak};
                r_stat_warn <= r_warn_full;
            end
        end
    end

    assign stat_peak = r_stat_peak;
    assign stat_warn = r_stat_warn;
`else
    // Statistics disabled: only the saturating OVF_LIMIT counter exists
`endif

endmodule
`default_nettype wire

// File: tb/tb_resize_gain_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_resize_gain_ctrl
// Brief    : Randomized self-checking bench for resize_gain_ctrl against a
//            window-level behavioural model (default parameters).
// Revision : 1.0 - initial release
//============================================================================
module tb_resize_gain_ctrl;

    localparam int DW     = 9;
    localparam int PAR    = 4;
    localparam int SW     = 5;
    localparam int WIN    = 1024;
    localparam int SETTLE = 4;
    localparam int OVF    = 1;
    localparam int SMIN   = -8;
    localparam int SMAX   = 8;
    localparam int LOW_TH = 64;   // 2^(9-2-1)

    localparam int M_LOW  = 0;    // magnitudes 0..63   -> increase
    localparam int M_MID  = 1;    // magnitudes 64..200 -> hold
    localparam int M_WARN = 2;    // magnitudes 0..20 plus one warning pulse
    localparam int M_NEG  = 3;    // small values with periodic -256 in lane 0

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  enable = 1'b0;
    logic [DW*PAR-1:0]     dout_mon = '0;
    logic                  dout_mon_valid = 1'b0;
    logic                  warning_in = 1'b0;
    logic signed [SW-1:0]  shift_out;
    logic                  shift_update;
    logic                  locked;
    logic                  at_rail;
`ifdef RESIZE_GAIN_CTRL_STATS_EN
    logic [DW:0]           stat_peak;
    logic [15:0]           stat_warn;
`endif

    resize_gain_ctrl u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .dout_mon       (dout_mon),
        .dout_mon_valid (dout_mon_valid),
        .warning_in     (warning_in),
        .shift_out      (shift_out),
        .shift_update   (shift_update),
        .locked         (locked),
        .at_rail        (at_rail)
`ifdef RESIZE_GAIN_CTRL_STATS_EN
        ,
        .stat_peak      (stat_peak),
        .stat_warn      (stat_warn)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_shift, m_upd, m_locked, m_rail;
    bit m_active, m_decide, m_decided;
    int m_settle, m_beats, m_peak, m_warns;
    int m_stat_peak, m_stat_warn;

    // stimulus bookkeeping
    int g_warn_at;
    bit g_warned;

    task automatic model_reset();
        m_shift = 0; m_upd = 0; m_locked = 0; m_rail = 0;
        m_active = 0; m_decide = 0; m_decided = 0;
        m_settle = 0; m_beats = 0; m_peak = 0; m_warns = 0;
        m_stat_peak = 0; m_stat_warn = 0;
    endtask

    task automatic clear_window();
        m_beats = 0; m_peak = 0; m_warns = 0;
    endtask

    // One clock edge of the model using the inputs the DUT just sampled
    task automatic model_step();
        int want;
        int v;
        m_upd = 0;
        if (!enable) begin
            m_active = 0; m_decide = 0; m_settle = 0;
            clear_window();
        end else if (!m_active) begin
            m_active = 1;
        end else if (m_decide) begin
            m_decide  = 0;
            m_decided = 1;
            want = 0;
            if (m_warns >= OVF)        want = -1;
            else if (m_peak < LOW_TH)  want = 1;
            m_stat_peak = m_peak;
            m_stat_warn = (m_warns > 65535) ? 65535 : m_warns;
            if (want != 0) begin
                m_locked = 0;
                if ((m_shift + want >= SMIN) && (m_shift + want <= SMAX)) begin
                    m_shift  = m_shift + want;
                    m_upd    = 1;
                    m_rail   = 0;
                    m_settle = SETTLE;
                end else begin
                    m_rail = 1;
                end
            end else begin
                m_locked = 1;
                m_rail   = 0;
            end
            clear_window();
        end else if (m_settle > 0) begin
            m_settle--;
        end else begin
            if (warning_in) m_warns++;
            if (dout_mon_valid) begin
                m_beats++;
                for (int i = 0; i < PAR; i++) begin
                    v = int'($signed(dout_mon[i*DW +: DW]));
                    if (v < 0) v = -v;
                    if (v > m_peak) m_peak = v;
                end
                if (m_beats == WIN) m_decide = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        check("shift_out",    int'(shift_out),    m_shift);
        check("shift_update", int'(shift_update), m_upd);
        check("locked",       int'(locked),       m_locked);
        check("at_rail",      int'(at_rail),      m_rail);
`ifdef RESIZE_GAIN_CTRL_STATS_EN
        check("stat_peak",    int'(stat_peak),    m_stat_peak);
        check("stat_warn",    int'(stat_warn),    m_stat_warn);
`endif
    endtask

    // Inputs for the next edge; blanked cycles get hostile data that must be ignored
    task automatic drive(input int mode);
        int mag;
        int val;
        bit quiet;
        quiet = !m_active || m_decide || (m_settle > 0);
        if (quiet) begin
            dout_mon_valid = 1'($urandom_range(1));
            warning_in     = 1'b1;
            for (int i = 0; i < PAR; i++) dout_mon[i*DW +: DW] = 9'h0FF;
        end else begin
            dout_mon_valid = ($urandom_range(7) != 0);
            warning_in     = 1'b0;
            for (int i = 0; i < PAR; i++) begin
                case (mode)
                    M_LOW:   mag = $urandom_range(63);
                    M_MID:   mag = $urandom_range(200, 64);
                    M_WARN:  mag = $urandom_range(20);
                    default: mag = $urandom_range(50);
                endcase
                val = $urandom_range(1) ? -mag : mag;
                if (mode == M_NEG && i == 0 && (m_beats % 64) == 7) val = -256;
                dout_mon[i*DW +: DW] = val[DW-1:0];
            end
            if (mode == M_WARN && !g_warned && m_beats >= g_warn_at) begin
                warning_in = 1'b1;
                g_warned   = 1'b1;
            end
        end
    endtask

    task automatic cycle(input int mode);
        drive(mode);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    // Run until the model has taken one window decision
    task automatic run_window(input int mode);
        int n;
        g_warned  = 0;
        g_warn_at = $urandom_range(1000, 10);
        m_decided = 0;
        n = 0;
        while (!m_decided && n < 4000) begin
            cycle(mode);
            n++;
        end
        if (!m_decided) check("window_timeout", 0, 1);
    endtask

    task automatic run_to_beat(input int mode, input int beat);
        int n;
        n = 0;
        while (m_beats < beat && n < 3000) begin
            cycle(mode);
            n++;
        end
        if (m_beats < beat) check("beat_timeout", m_beats, beat);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_shift",  int'(shift_out),    0);
        check("rst_update", int'(shift_update), 0);
        check("rst_locked", int'(locked),       0);
        check("rst_rail",   int'(at_rail),      0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Three quiet low-peak windows step the shift up
        for (int k = 0; k < 3; k++) run_window(M_LOW);
        check("up3_shift", int'(shift_out), 3);

        // Mid-range peak holds and locks
        run_window(M_MID);
        check("hold_locked", int'(locked),    1);
        check("hold_shift",  int'(shift_out), 3);

        // Low peak plus one warning: overflow wins
        run_window(M_WARN);
        check("warn_shift",  int'(shift_out), 2);
        check("warn_locked", int'(locked),    0);

        // Climb to the upper rail, then one more low window clamps
        for (int k = 0; k < 6; k++) run_window(M_LOW);
        check("top_shift", int'(shift_out), 8);
        run_window(M_LOW);
        check("top_rail",       int'(at_rail),   1);
        check("top_rail_shift", int'(shift_out), 8);

        // Most-negative code saturates to 256 and holds
        run_window(M_NEG);
        check("neg_locked", int'(locked),  1);
        check("neg_rail",   int'(at_rail), 0);
`ifdef RESIZE_GAIN_CTRL_STATS_EN
        check("neg_stat_peak", int'(stat_peak), 256);
`endif

        // Descend to the lower rail, then clamp
        for (int k = 0; k < 16; k++) run_window(M_WARN);
        check("bot_shift", int'(shift_out), -8);
        run_window(M_WARN);
        check("bot_rail",       int'(at_rail),   1);
        check("bot_rail_shift", int'(shift_out), -8);

        // Drop enable mid-window; the next window starts from scratch
        run_to_beat(M_LOW, 500);
        enable = 1'b0;
        for (int k = 0; k < 20; k++) cycle(M_LOW);
        check("dis_shift", int'(shift_out), -8);
        enable = 1'b1;
        run_window(M_LOW);
        check("reen_shift", int'(shift_out), -7);

        // Asynchronous reset mid-window takes effect without a clock edge
        run_to_beat(M_LOW, 300);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_shift",  int'(shift_out),    0);
        check("async_update", int'(shift_update), 0);
        check("async_locked", int'(locked),       0);
        check("async_rail",   int'(at_rail),      0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_window(M_LOW);
        check("post_rst_shift", int'(shift_out), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
